// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side controller with 2-entry skid buffer and packet framing
module fifo_reader #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic          fifo_wr_acc,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [CW-1:0] rd_count
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  logic [1:0]    occ;
  logic          inflight;
  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [7:0]    pkt_cnt;

  logic          pop;
  logic [1:0]    occ_after_pop;
  logic [1:0]    credit_used;

  // Credits count both held bytes and the byte still coming back from the FIFO;
  // a same-cycle pop frees a slot early so streaming sustains one byte per cycle.
  assign pop           = m_valid && m_ready;
  assign occ_after_pop = occ - {1'b0, pop};
  assign credit_used   = occ_after_pop + {1'b0, inflight};
  // Gated by reset so no read escapes while the controller is held in reset.
  assign fifo_rd       = rst && en && !fifo_empty && (credit_used < 2'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = e0;
  assign m_last  = m_valid && (pkt_cnt == LAST_IDX);

  // Occupancy and in-flight tracking; a read the FIFO ignored (write priority) is simply retried.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= credit_used;
      inflight <= fifo_rd && !fifo_wr_acc;
    end
  end

  // Skid buffer data: shift on pop, then land the returning byte in the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0 <= '0;
      e1 <= '0;
    end else begin
      if (pop) begin
        e0 <= e1;
      end
      if (inflight) begin
        if (occ_after_pop == 2'd0) begin
          e0 <= fifo_dout;
        end else begin
          e1 <= fifo_dout;
        end
      end
    end
  end

  // Packet position and delivered-byte counter advance only on accepted output bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt  <= 8'd0;
      rd_count <= '0;
    end else if (pop) begin
      pkt_cnt  <= (pkt_cnt == LAST_IDX) ? 8'd0 : pkt_cnt + 8'd1;
      rd_count <= rd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader with queue-based FIFO and stream model
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic       fifo_wr_acc;
  logic [7:0] fifo_dout;
  logic       m_ready;

  logic       fifo_rd, m_valid, m_last;
  logic [7:0] m_data;
  logic [15:0] rd_count;

  logic       w_rd, w_valid, w_last;
  logic [7:0] w_data;
  logic [3:0] w_count;

  always #5 clk = ~clk;

  fifo_reader #(.DW(8), .PKT_LEN(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .fifo_wr_acc(fifo_wr_acc), .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .rd_count(rd_count)
  );

  fifo_reader #(.DW(8), .PKT_LEN(3), .CW(4)) dut_w (
    .clk(clk), .rst(rst), .en(en), .fifo_rd(w_rd), .fifo_empty(fifo_empty),
    .fifo_wr_acc(fifo_wr_acc), .fifo_dout(fifo_dout), .m_valid(w_valid), .m_ready(m_ready),
    .m_data(w_data), .m_last(w_last), .rd_count(w_count)
  );

  int total = 0;
  int bad   = 0;

  // FIFO contents, bytes read from the FIFO not yet delivered, and stream counters.
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] wdata;
  int         held;
  int         inflight;
  int         delivered;

  logic       s_rd, s_valid, s_last;
  logic [7:0] s_data;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rd;
    logic       valid;
    logic [7:0] data;
    logic       last;
  } row_t;
  row_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int npre, input logic [7:0] first);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; m_ready = 1'b0; fifo_wr_acc = 1'b0; fifo_dout = 8'h00;
    q.delete(); exp_q.delete();
    held = 0; inflight = 0; delivered = 0;
    wdata = first;
    for (int i = 0; i < npre; i++) begin
      q.push_back(wdata);
      wdata = wdata + 8'd1;
    end
    fifo_empty = (q.size() == 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset_fifo_rd", int'(fifo_rd), 0);
      chk("reset_m_valid", int'(m_valid), 0);
      chk("reset_m_data", int'(m_data), 0);
      chk("reset_m_last", int'(m_last), 0);
      chk("reset_rd_count", int'(rd_count), 0);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model past the edge.
  task automatic step(input logic e, input logic r, input logic w);
    logic exp_rd, exp_v, pop, acc;
    @(negedge clk);
    rst = 1'b1;
    en = e; m_ready = r;
    fifo_wr_acc = w && (q.size() < 16);
    fifo_empty = (q.size() == 0);
    #1;
    s_rd = fifo_rd; s_valid = m_valid; s_data = m_data; s_last = m_last;
    exp_v  = (held > 0);
    pop    = exp_v && r;
    exp_rd = e && !fifo_empty && ((held + inflight - int'(pop)) < 2);
    chk("fifo_rd", int'(fifo_rd), int'(exp_rd));
    chk("m_valid", int'(m_valid), int'(exp_v));
    chk("rd_count", int'(rd_count), delivered % 65536);
    chk("w_fifo_rd", int'(w_rd), int'(exp_rd));
    chk("w_m_valid", int'(w_valid), int'(exp_v));
    chk("w_rd_count", int'(w_count), delivered % 16);
    if (exp_v) begin
      chk("m_data", int'(m_data), int'(exp_q[0]));
      chk("m_last", int'(m_last), int'((delivered % 4) == 3));
      chk("w_m_data", int'(w_data), int'(exp_q[0]));
      chk("w_m_last", int'(w_last), int'((delivered % 3) == 2));
    end
    acc = exp_rd && !fifo_wr_acc;
    @(posedge clk); #1;
    if (pop) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    held = held + inflight - int'(pop);
    if (fifo_wr_acc) begin
      q.push_back(wdata);
      wdata = wdata + 8'd1;
    end
    if (acc) begin
      fifo_dout = q.pop_front();
      exp_q.push_back(fifo_dout);
    end
    inflight = int'(acc);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_wr_acc = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    held = 0; inflight = 0; delivered = 0; wdata = 8'h00;

    // Start-up latency and first packet with 5 stored bytes, ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    do_reset(5, 8'h10);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_rd", i), int'(s_rd), int'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), int'(s_valid), int'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_data", i), int'(s_data), int'(tbl[i].data));
        chk($sformatf("tbl%0d_last", i), int'(s_last), int'(tbl[i].last));
      end
    end

    // Streaming 16 bytes, then two more to wrap the 4-bit counter.
    do_reset(16, 8'h10);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    chk("stream_rd_count", int'(rd_count), 16);
    chk("stream_w_count", int'(w_count), 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    chk("wrap_rd_count", int'(rd_count), 18);
    chk("wrap_w_count", int'(w_count), 2);

    // Backpressure with ready pattern 1,0,0,1.
    do_reset(8, 8'hA0);
    for (int i = 0; i < 40; i++) step(1'b1, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    chk("bp_rd_count", int'(rd_count), 8);

    // Write collisions while reads are pending.
    do_reset(4, 8'h30);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    chk("coll_rd_count", int'(rd_count), 7);

    // Enable gating: two reads issued, then en low, then resume.
    do_reset(6, 8'h50);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("gate_rd_count", int'(rd_count), 2);
    chk("gate_m_valid", int'(s_valid), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("gate_resume_count", int'(rd_count), 6);

    // Randomised traffic against the model, then drain.
    do_reset(3, 8'h00);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    chk("drain_m_valid", int'(s_valid), 0);
    chk("drain_fifo_rd", int'(s_rd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
